alu_sequencer: RTL and testbench

// - Control unit of the 4-bit processor: fetches 8-bit instructions, drives the ALU, owns ACC and PC.
// - ALU is a registered peer: opcode/a/b in, result/flag out.
// - Multi-cycle FSM: fetch -> decode -> issue -> wait ALU latency -> writeback. One instruction in flight.

---
 rtl/proc_pkg.sv | 51 +++++
 rtl/seq_pc_counter.sv | 32 +++
 rtl/alu_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : proc_pkg
// Description : Shared opcodes, FSM state encoding and flag bit positions for
//               the 4-bit processor control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

   // Instruction opcodes (instr[7:4])
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_CMP  = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Sequencer FSM states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_ISSUE  = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_HALTED = 3'd6;

   // Bit positions inside alu_flag / flags
   localparam int FLAG_LT = 4;
   localparam int FLAG_GT = 3;
   localparam int FLAG_EQ = 2;
   localparam int FLAG_C  = 1;
   localparam int FLAG_B  = 0;

   // Opcodes that go through the external ALU
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_CMP);
   endfunction

   // ALU opcodes whose result lands in the accumulator (CMP only sets flags)
   function automatic logic writes_acc(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pc_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : seq_pc_counter
// Description : Program counter with synchronous load / increment and
//               asynchronous active-low clear. Increment wraps modulo 2**PC_W.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pc_counter #(
   parameter int PC_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [PC_W-1:0] load_val,
   input  logic            inc,
   output logic [PC_W-1:0] pc
);

   // Load has priority over increment; natural overflow gives the wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle control unit of the 4-bit processor. Fetches
//               8-bit instructions, issues ALU operations to a registered
//               external ALU, and owns the accumulator and program counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
   import proc_pkg::*;
#(
   parameter int ALU_LAT = 2,
   parameter int PC_W    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            imem_rd_en,
   output logic [PC_W-1:0] imem_addr,
   input  logic [7:0]      imem_rdata,
   input  logic            imem_valid,
   output logic [3:0]      alu_opcode,
   output logic [3:0]      alu_a,
   output logic [3:0]      alu_b,
   input  logic [3:0]      alu_result,
   input  logic [4:0]      alu_flag,
   output logic [3:0]      acc,
   output logic [4:0]      flags,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted
);

   // Last value of the latency counter while in WAIT (counter reads 1 after ISSUE)
   localparam logic [2:0] LAST_WAIT = 3'(ALU_LAT - 1);

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic [7:0]      instr;
   logic [2:0]      lat_cnt;
   logic            pc_load;
   logic            pc_inc;
   logic [PC_W-1:0] pc_load_val;
   logic [PC_W-1:0] jump_target;

   wire [3:0] op  = instr[7:4];
   wire [3:0] imm = instr[3:0];

   // Jump target is the immediate, truncated or zero-extended to the PC width
   generate
      if (PC_W <= 4) begin : g_tgt_narrow
         assign jump_target = imm[PC_W-1:0];
      end else begin : g_tgt_wide
         assign jump_target = {{(PC_W-4){1'b0}}, imm};
      end
   endgenerate

   assign imem_addr = pc;

   seq_pc_counter #(
      .PC_W (PC_W)
   ) u_pc (
      .clk      (clk),
      .rst_n    (reset),
      .load     (pc_load),
      .load_val (pc_load_val),
      .inc      (pc_inc),
      .pc       (pc)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: one instruction in flight, start only honoured when idle/halted
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_HALTED: begin
            if (start) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_valid) state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            if (is_alu_op(op))       state_nxt = ST_ISSUE;
            else if (op == OP_HALT)  state_nxt = ST_HALTED;
            else                     state_nxt = ST_FETCH;
         end
         ST_ISSUE: begin
            state_nxt = (ALU_LAT == 1) ? ST_WB : ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_cnt == LAST_WAIT) state_nxt = ST_WB;
         end
         ST_WB: begin
            state_nxt = ST_FETCH;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode: memory request, ALU drive window and PC control per state
   always_comb begin
      imem_rd_en  = 1'b0;
      alu_opcode  = 4'b0000;
      alu_a       = 4'b0000;
      alu_b       = 4'b0000;
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_load_val = '0;
      busy        = (state != ST_IDLE) && (state != ST_HALTED);
      halted      = (state == ST_HALTED);
      case (state)
         ST_IDLE, ST_HALTED: begin
            pc_load = start;
         end
         ST_FETCH: begin
            imem_rd_en = 1'b1;
         end
         ST_DECODE: begin
            case (op)
               OP_LDI: begin
                  pc_inc = 1'b1;
               end
               OP_JMP: begin
                  pc_load     = 1'b1;
                  pc_load_val = jump_target;
               end
               OP_JZ: begin
                  if (acc == 4'd0) begin
                     pc_load     = 1'b1;
                     pc_load_val = jump_target;
                  end else begin
                     pc_inc = 1'b1;
                  end
               end
               OP_HALT: begin
                  pc_inc = 1'b0;
               end
               default: begin
                  // NOP and unassigned opcodes just advance; ALU ops advance at WB
                  pc_inc = !is_alu_op(op);
               end
            endcase
         end
         ST_ISSUE, ST_WAIT: begin
            alu_opcode = op;
            alu_a      = imm;
            alu_b      = acc;
         end
         ST_WB: begin
            pc_inc = 1'b1;
         end
         default: begin
            pc_inc = 1'b0;
         end
      endcase
   end

   // Datapath: instruction latch, ALU latency counter, accumulator and flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr   <= 8'h00;
         lat_cnt <= 3'd0;
         acc     <= 4'd0;
         flags   <= 5'd0;
      end else begin
         if ((state == ST_FETCH) && imem_valid) begin
            instr <= imem_rdata;
         end
         if (state == ST_ISSUE) begin
            lat_cnt <= 3'd1;
         end else if (state == ST_WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
         end
         if ((state == ST_DECODE) && (op == OP_LDI)) begin
            acc <= imm;
         end else if ((state == ST_WB) && writes_acc(op)) begin
            acc <= alu_result;
         end
         if (state == ST_WB) begin
            flags <= alu_flag;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with an instruction ROM
//               of programmable latency, a behavioural pipelined ALU and an
//               instruction-level reference interpreter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

   localparam int ALU_LAT = 2;
   localparam int PC_W    = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            imem_rd_en;
   logic [PC_W-1:0] imem_addr;
   logic [7:0]      imem_rdata;
   logic            imem_valid;
   logic [3:0]      alu_opcode;
   logic [3:0]      alu_a;
   logic [3:0]      alu_b;
   logic [3:0]      alu_result;
   logic [4:0]      alu_flag;
   logic [3:0]      acc;
   logic [4:0]      flags;
   logic [PC_W-1:0] pc;
   logic            busy;
   logic            halted;

   int vectors    = 0;
   int miscompares = 0;

   alu_sequencer #(
      .ALU_LAT (ALU_LAT),
      .PC_W    (PC_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .imem_rd_en (imem_rd_en),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_valid (imem_valid),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_flag   (alu_flag),
      .acc        (acc),
      .flags      (flags),
      .pc         (pc),
      .busy       (busy),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   // ---------------- instruction ROM with programmable valid delay ----------
   logic [7:0] rom [16];
   int fetch_delay = 0;
   int wait_cnt    = 0;

   assign imem_rdata = rom[imem_addr];
   assign imem_valid = imem_rd_en && (wait_cnt >= fetch_delay);

   always @(posedge clk) begin
      if (imem_rd_en && !imem_valid) wait_cnt <= wait_cnt + 1;
      else                           wait_cnt <= 0;
   end

   // ---------------- behavioural ALU: {flags,result} after ALU_LAT edges ----
   // lt/gt/eq compare the accumulator (b) against the immediate (a)
   function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
      logic [3:0] res;
      logic [4:0] fl;
      int         sum;
      sum = int'(a) + int'(b);
      case (op)
         4'h1:    res = a + b;
         4'h2:    res = b - a;
         4'h3:    res = a & b;
         4'h4:    res = a | b;
         4'h5:    res = a ^ b;
         4'h6:    res = b - a;
         default: res = 4'h0;
      endcase
      fl[4] = (b < a);
      fl[3] = (b > a);
      fl[2] = (a == b);
      fl[1] = (op == 4'h1) && (sum > 15);
      fl[0] = (op == 4'h2) && (b < a);
      return {fl, res};
   endfunction

   logic [8:0] alu_pipe [ALU_LAT];
   always @(posedge clk) begin
      alu_pipe[0] <= alu_fn(alu_opcode, alu_a, alu_b);
      for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
   end
   assign alu_flag   = alu_pipe[ALU_LAT-1][8:4];
   assign alu_result = alu_pipe[ALU_LAT-1][3:0];

   // ---------------- monitors --------------------------------------------------
   logic [3:0] dut_trace [$];
   bit         collecting = 1'b0;
   bit         busy_drop  = 1'b0;
   int         hold_cnt    = 0;
   int         stall_err   = 0;
   int         stall_cycles = 0;
   logic       prev_stall  = 1'b0;
   logic [3:0] prev_addr   = 4'd0;

   always @(negedge clk) begin
      if (collecting && imem_rd_en && imem_valid) dut_trace.push_back(imem_addr);
      if (alu_opcode == 4'h1 && alu_a == 4'd5 && alu_b == 4'd3) hold_cnt++;
      if (prev_stall && (!imem_rd_en || imem_addr != prev_addr)) stall_err++;
      if (imem_rd_en && !imem_valid) stall_cycles++;
      prev_stall = imem_rd_en && !imem_valid;
      prev_addr  = imem_addr;
   end

   // ---------------- instruction-level reference model ----------------------
   logic [3:0] m_acc   = 4'd0;
   logic [4:0] m_flags = 5'd0;
   logic [3:0] e_acc;
   logic [4:0] e_flags;
   logic [3:0] e_pc;
   bit         e_halted;
   int         e_cycles;
   logic [3:0] e_trace [$];

   task automatic model_run(input int delay, input int max_instr);
      logic [3:0] p;
      logic [3:0] op;
      logic [3:0] imm;
      logic [8:0] r;
      p = 4'd0;
      e_halted = 1'b0;
      e_cycles = 1;
      e_trace.delete();
      for (int k = 0; k < max_instr && !e_halted; k++) begin
         e_trace.push_back(p);
         op  = rom[p][7:4];
         imm = rom[p][3:0];
         if (op >= 4'h1 && op <= 4'h6) begin
            r = alu_fn(op, imm, m_acc);
            if (op != 4'h6) m_acc = r[3:0];
            m_flags = r[8:4];
            p = p + 4'd1;
            e_cycles += 3 + ALU_LAT + delay;
         end else begin
            e_cycles += 2 + delay;
            case (op)
               4'h7: begin m_acc = imm; p = p + 4'd1; end
               4'h8: p = imm;
               4'h9: p = (m_acc == 4'd0) ? imm : p + 4'd1;
               4'hF: e_halted = 1'b1;
               default: p = p + 4'd1;
            endcase
         end
      end
      e_pc    = p;
      e_acc   = m_acc;
      e_flags = m_flags;
   endtask

   // ---------------- stimulus driver ----------------------------------------
   task automatic run_program(input int delay, input int max_cycles, input bit spam_start,
                              output int cycles, output bit timed_out);
      fetch_delay = delay;
      @(negedge clk);
      dut_trace.delete();
      collecting = 1'b1;
      busy_drop  = 1'b0;
      start      = 1'b1;
      cycles     = 0;
      timed_out  = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         start = spam_start ? imem_valid : 1'b0;
         if (halted) begin
            timed_out = 1'b0;
            break;
         end
         if (!busy) busy_drop = 1'b1;
      end
      start      = 1'b0;
      collecting = 1'b0;
   endtask

   task automatic fill_rom(input logic [7:0] val);
      for (int i = 0; i < 16; i++) rom[i] = val;
   endtask

   // ---------------- tests --------------------------------------------------
   task automatic test_reset;
      #1;
      vectors++;
      if (pc !== 4'd0 || acc !== 4'd0 || flags !== 5'd0) begin
         miscompares++;
         $display("FAIL reset_regs: pc=%0d acc=%0d flags=%b, expected 0/0/00000", pc, acc, flags);
      end
      vectors++;
      if ({alu_opcode, alu_a, alu_b} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_alu: op=%h a=%h b=%h, expected 0", alu_opcode, alu_a, alu_b);
      end
      vectors++;
      if ({imem_rd_en, busy, halted} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_ctrl: rd_en=%b busy=%b halted=%b, expected 000", imem_rd_en, busy, halted);
      end
   endtask

   task automatic test_ldi_add;
      int cyc; bit to; int h0;
      fill_rom(8'hF0);
      rom[0] = 8'h73; rom[1] = 8'h15; rom[2] = 8'hF0;
      model_run(0, 32);
      h0 = hold_cnt;
      run_program(0, 100, 1'b0, cyc, to);
      vectors++;
      if (to !== 1'b0 || halted !== 1'b1) begin
         miscompares++;
         $display("FAIL add_halt: timed_out=%b halted=%b, expected 0/1", to, halted);
      end
      vectors++;
      if (acc !== 4'd8) begin
         miscompares++;
         $display("FAIL add_acc: got %0d expected 8", acc);
      end
      vectors++;
      if (pc !== 4'd2) begin
         miscompares++;
         $display("FAIL add_pc: got %0d expected 2", pc);
      end
      vectors++;
      if (cyc !== 1 + 2 + (3 + ALU_LAT) + 2) begin
         miscompares++;
         $display("FAIL add_cycles: got %0d expected %0d", cyc, 1 + 2 + (3 + ALU_LAT) + 2);
      end
      vectors++;
      if (hold_cnt - h0 !== ALU_LAT) begin
         miscompares++;
         $display("FAIL add_operand_hold: got %0d cycles expected %0d", hold_cnt - h0, ALU_LAT);
      end
      vectors++;
      if (flags !== e_flags) begin
         miscompares++;
         $display("FAIL add_flags: got %b expected %b", flags, e_flags);
      end
   endtask

   task automatic test_cmp;
      int cyc; bit to;
      fill_rom(8'hF0);
      rom[0] = 8'h74; rom[1] = 8'h64;
      model_run(0, 32);
      run_program(0, 100, 1'b0, cyc, to);
      vectors++;
      if (acc !== 4'd4 || flags !== 5'b00100) begin
         miscompares++;
         $display("FAIL cmp_eq: acc=%0d flags=%b, expected 4/00100", acc, flags);
      end
      fill_rom(8'hF0);
      rom[0] = 8'h69;
      model_run(0, 32);
      run_program(0, 100, 1'b0, cyc, to);
      vectors++;
      if (acc !== 4'd4 || flags !== 5'b10000 || pc !== 4'd1) begin
         miscompares++;
         $display("FAIL cmp_lt: acc=%0d flags=%b pc=%0d, expected 4/10000/1", acc, flags, pc);
      end
   endtask

   task automatic test_jz;
      int cyc; bit to;
      fill_rom(8'hF0);
      rom[0] = 8'h70; rom[1] = 8'h95;
      model_run(0, 32);
      run_program(0, 100, 1'b0, cyc, to);
      vectors++;
      if (pc !== 4'd5 || dut_trace.size() != 3 || dut_trace[2] !== 4'd5) begin
         miscompares++;
         $display("FAIL jz_taken: pc=%0d fetches=%0d, expected pc 5 after 3 fetches", pc, dut_trace.size());
      end
      rom[0] = 8'h71;
      model_run(0, 32);
      run_program(0, 100, 1'b0, cyc, to);
      vectors++;
      if (pc !== 4'd2 || dut_trace.size() != 3 || dut_trace[2] !== 4'd2) begin
         miscompares++;
         $display("FAIL jz_not_taken: pc=%0d fetches=%0d, expected pc 2 after 3 fetches", pc, dut_trace.size());
      end
   endtask

   task automatic test_stall;
      int cyc; bit to; int e0; int s0; bit bad;
      fill_rom(8'hF0);
      rom[0] = 8'h73; rom[1] = 8'h15; rom[2] = 8'hF0;
      model_run(3, 32);
      e0 = stall_err;
      s0 = stall_cycles;
      run_program(3, 200, 1'b1, cyc, to);
      vectors++;
      if (acc !== 4'd8 || pc !== 4'd2 || cyc !== e_cycles) begin
         miscompares++;
         $display("FAIL stall_result: acc=%0d pc=%0d cycles=%0d, expected 8/2/%0d", acc, pc, cyc, e_cycles);
      end
      vectors++;
      if (stall_err - e0 !== 0 || stall_cycles - s0 !== 9) begin
         miscompares++;
         $display("FAIL stall_hold: unstable=%0d stall_cycles=%0d, expected 0/9", stall_err - e0, stall_cycles - s0);
      end
      bad = (dut_trace.size() != e_trace.size());
      for (int i = 0; i < e_trace.size() && !bad; i++) if (dut_trace[i] !== e_trace[i]) bad = 1'b1;
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL stall_trace: got %0d fetches expected %0d (start must be ignored)", dut_trace.size(), e_trace.size());
      end
   endtask

   task automatic test_reset_mid;
      int cyc; bit to; bit found;
      fill_rom(8'hF0);
      rom[0] = 8'h73; rom[1] = 8'h15; rom[2] = 8'hF0;
      fetch_delay = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (alu_opcode != 4'h0) begin
            found = 1'b1;
            break;
         end
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL rst_mid_issue: alu_opcode got 0 for 20 cycles, expected ADD issue");
      end
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      vectors++;
      if ({acc, flags, pc} !== 13'd0 || {alu_opcode, alu_a, alu_b} !== 12'h000 ||
          {imem_rd_en, busy, halted} !== 3'b000) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: acc=%0d flags=%b pc=%0d op=%h busy=%b, expected all 0",
                  acc, flags, pc, alu_opcode, busy);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      vectors++;
      if (acc !== 4'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_no_wb: acc=%0d busy=%b, expected 0/0", acc, busy);
      end
      m_acc = 4'd0;
      m_flags = 5'd0;
      model_run(0, 32);
      run_program(0, 100, 1'b0, cyc, to);
      vectors++;
      if (dut_trace.size() != 3 || dut_trace[0] !== 4'd0 || acc !== 4'd8) begin
         miscompares++;
         $display("FAIL rst_mid_restart: fetches=%0d acc=%0d, expected 3 fetches from pc 0, acc 8",
                  dut_trace.size(), acc);
      end
   endtask

   task automatic test_wrap;
      int cyc; bit to; bit bad;
      fill_rom(8'h00);
      model_run(0, 18);
      run_program(0, 40, 1'b0, cyc, to);
      vectors++;
      if (to !== 1'b1 || busy_drop !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_busy: timed_out=%b busy_dropped=%b, expected 1/0", to, busy_drop);
      end
      bad = (dut_trace.size() < 18);
      for (int i = 0; i < 18 && !bad; i++) if (dut_trace[i] !== e_trace[i]) bad = 1'b1;
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL wrap_trace: got %0d fetches, expected addresses 0..15,0,1 in order", dut_trace.size());
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_acc = 4'd0;
      m_flags = 5'd0;
   endtask

   task automatic test_random;
      int cyc; bit to; bit bad; int d; int k;
      logic [3:0] op; logic [3:0] imm;
      for (int n = 0; n < 12; n++) begin
         for (int a = 0; a < 15; a++) begin
            k   = $urandom_range(0, 9);
            imm = 4'($urandom_range(0, 15));
            case (k)
               0, 1, 2, 3, 4, 5: op = 4'(k + 1);
               6: op = 4'h7;
               7: op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(10, 14));
               8: begin op = 4'h8; imm = 4'($urandom_range(a + 1, 15)); end
               default: begin op = 4'h9; imm = 4'($urandom_range(a + 1, 15)); end
            endcase
            rom[a] = {op, imm};
         end
         rom[15] = 8'hF0;
         d = $urandom_range(0, 2);
         model_run(d, 32);
         run_program(d, 400, 1'b0, cyc, to);
         vectors++;
         if (to !== 1'b0 || acc !== e_acc || flags !== e_flags || pc !== e_pc) begin
            miscompares++;
            $display("FAIL rand%0d_state: to=%b acc=%0d flags=%b pc=%0d, expected 0/%0d/%b/%0d",
                     n, to, acc, flags, pc, e_acc, e_flags, e_pc);
         end
         vectors++;
         if (cyc !== e_cycles) begin
            miscompares++;
            $display("FAIL rand%0d_cycles: got %0d expected %0d", n, cyc, e_cycles);
         end
         bad = (dut_trace.size() != e_trace.size());
         for (int i = 0; i < e_trace.size() && !bad; i++) if (dut_trace[i] !== e_trace[i]) bad = 1'b1;
         vectors++;
         if (bad) begin
            miscompares++;
            $display("FAIL rand%0d_trace: got %0d fetches expected %0d", n, dut_trace.size(), e_trace.size());
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      fill_rom(8'hF0);
      repeat (3) @(negedge clk);
      test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      test_ldi_add;
      test_cmp;
      test_jz;
      test_stall;
      test_reset_mid;
      test_wrap;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
